uart_rx_frame_ctrl: RTL

- Sequences the byte stream produced by the UART receiver into validated frames, and controls the write side of the async FIFO.
- Frame format: SYNC byte, LEN byte (1..MAX_LEN), LEN payload bytes, then an XOR checksum byte.
- Payload is held in an internal buffer and is written to the FIFO only after the checksum passes. Corrupt, truncated or oversized frames therefore never reach the FIFO.

---
 rtl/uart_rx_frame_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Assembles bytes from a UART receiver into frames of the form
// SYNC, LEN (1..MAX_LEN), LEN payload bytes, XOR checksum. Payload bytes are
// held in a local buffer and are pushed into the async FIFO only after the
// checksum matches. Bad, truncated or oversized frames never reach the FIFO.
//
// Ports:
//   clk           system clock (16 x baud)
//   rst           synchronous reset, active high
//   rx_data       received byte, valid while rx_done is high
//   rx_done       one-cycle strobe per received byte
//   fifo_full     FIFO write-side full flag
//   fifo_wr_en    FIFO write enable (combinational)
//   fifo_wr_data  FIFO write data (combinational, 0 outside DRAIN)
//   busy          high in every state except HUNT
//   frame_ok      pulse: frame completely written to the FIFO
//   csum_err      pulse: checksum mismatch
//   len_err       pulse: LEN byte is 0 or greater than MAX_LEN
//   timeout_err   pulse: inter-byte gap reached TIMEOUT_CYCLES
//   overrun_err   pulse: byte arrived during DRAIN and was dropped
//   frame_cnt     good-frame counter, wraps at 16 bits
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic        busy,
  output logic        frame_ok,
  output logic        csum_err,
  output logic        len_err,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(MAX_LEN) + 1;  // len / pointer width
  localparam int AW = PW - 1;               // buffer address width
  localparam int GW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] len, wr_ptr, rd_ptr;
  logic [7:0]    csum;
  logic [GW-1:0] gap;
  logic [7:0]    mem [MAX_LEN];

  logic in_frame, gap_hit, len_bad, last_wr, drain_last, drain_wr;
  logic ok_nxt, cs_nxt, len_nxt, tmo_nxt;

  assign in_frame   = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  // A byte landing on the final gap cycle takes priority over the timeout.
  assign gap_hit    = in_frame && !rx_done && (gap == GW'(TIMEOUT_CYCLES - 1));
  assign len_bad    = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(MAX_LEN));
  assign last_wr    = (wr_ptr == len - PW'(1));
  assign drain_last = (rd_ptr == len - PW'(1));
  assign drain_wr   = (state == DRAIN) && !fifo_full;

  assign fifo_wr_en   = drain_wr;
  assign fifo_wr_data = (state == DRAIN) ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign busy         = (state != HUNT);

  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    cs_nxt    = 1'b0;
    len_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    if (gap_hit) begin
      state_nxt = HUNT;
      tmo_nxt   = 1'b1;
    end else begin
      case (state)
        HUNT:
          if (rx_done && rx_data == SYNC_BYTE) state_nxt = LEN;
        LEN:
          if (rx_done) begin
            if (len_bad) begin
              state_nxt = HUNT;
              len_nxt   = 1'b1;
            end else begin
              state_nxt = PAYLOAD;
            end
          end
        PAYLOAD:
          if (rx_done && last_wr) state_nxt = CSUM;
        CSUM:
          if (rx_done) begin
            if (rx_data == csum) begin
              state_nxt = DRAIN;
            end else begin
              state_nxt = HUNT;
              cs_nxt    = 1'b1;
            end
          end
        DRAIN:
          if (drain_wr && drain_last) begin
            state_nxt = HUNT;
            ok_nxt    = 1'b1;
          end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      len         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      csum        <= '0;
      gap         <= '0;
      frame_cnt   <= '0;
      frame_ok    <= 1'b0;
      csum_err    <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_ok    <= ok_nxt;
      csum_err    <= cs_nxt;
      len_err     <= len_nxt;
      timeout_err <= tmo_nxt;
      // Bytes arriving while draining are dropped; the drain is not disturbed.
      overrun_err <= (state == DRAIN) && rx_done;

      // Gap counter clears on each byte and on every state change, so it also
      // starts from zero on entry to LEN/PAYLOAD/CSUM.
      if (!in_frame || rx_done || state_nxt != state) gap <= '0;
      else                                            gap <= gap + GW'(1);

      case (state)
        LEN:
          if (rx_done && !len_bad && !gap_hit) begin
            len    <= PW'(rx_data);
            csum   <= rx_data;
            wr_ptr <= '0;
          end
        PAYLOAD:
          if (rx_done) begin
            csum   <= csum ^ rx_data;
            wr_ptr <= wr_ptr + PW'(1);
          end
        CSUM:
          if (rx_done && rx_data == csum) rd_ptr <= '0;
        DRAIN:
          if (drain_wr) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (drain_last) frame_cnt <= frame_cnt + 16'd1;
          end
        default: ;
      endcase
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_done) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

endmodule
